// File: rtl/shift_add_multiplier_ctrl.sv
// Sequential unsigned shift-and-add multiplier.
// One ripple-carry adder is reused each cycle, and a small FSM provides the start/busy/done handshake.

module single_bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_multiplier_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 done
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH:0]     carry;
   logic [2*WIDTH-1:0] shifted;
   logic               last_step;

   // Each cycle adds the partial product for the current multiplier LSB.
   assign addend   = mplr_q[0] ? mcand_q : '0;
   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adder
         single_bit_full_adder u_fa (
            .a    (acc_q[gi]),
            .b    (addend[gi]),
            .cin  (carry[gi]),
            .s    (sum[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   // The carry out becomes the new accumulator MSB, so the full product is never truncated.
   assign shifted   = {carry[WIDTH], sum, mplr_q[WIDTH-1:1]};
   assign last_step = (count_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CALC;
         S_CALC:  if (last_step) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_CALC: busy = 1'b1;
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mcand_d = multiplicand;
               mplr_d  = multiplier;
               acc_d   = '0;
               count_d = '0;
            end
         end
         S_CALC: begin
            {acc_d, mplr_d} = shifted;
            count_d         = count_q + CW'(1);
            if (last_step) product_d = shifted;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Directed checks for the shift-add multiplier.
// The WIDTH=4 instance covers the main tests, and a WIDTH=8 instance covers the maximum-operand case.

module tb_shift_add_multiplier_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  a_in = '0;
   logic [3:0]  b_in = '0;
   logic [7:0]  prod;
   logic        busy, done;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [15:0] prod8;
   logic        busy8, done8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   shift_add_multiplier_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .multiplicand(a_in), .multiplier(b_in),
      .product(prod), .busy(busy), .done(done)
   );

   shift_add_multiplier_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8),
      .multiplicand(a8), .multiplier(b8),
      .product(prod8), .busy(busy8), .done(done8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Run one WIDTH=4 multiply and check its latency, busy span, product and single done pulse.
   task automatic run_op(input string tag, input int a, input int b, input int exp_p, input bit full);
      int n;
      int busy_cnt;
      @(negedge clk);
      start = 1'b1;
      a_in  = 4'(a);
      b_in  = 4'(b);
      @(posedge clk); #1;
      start    = 1'b0;
      a_in     = 4'($urandom);
      b_in     = 4'($urandom);
      busy_cnt = busy ? 1 : 0;
      n        = 0;
      while (n < 20 && !done) begin
         @(posedge clk); #1;
         n++;
         if (busy) busy_cnt++;
      end
      check({tag, "_prod"}, 32'(prod), 32'(exp_p));
      if (full) begin
         check({tag, "_lat"}, 32'(n), 32'd4);
         check({tag, "_busycyc"}, 32'(busy_cnt), 32'd5);
      end
      @(posedge clk); #1;
      check({tag, "_onedone"}, {31'd0, done}, 32'd0);
      if (full) check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   function automatic int opa(input int e);
      return (e * 7 + 3) % 16;
   endfunction

   function automatic int opb(input int e);
      return (e * 5 + 11) % 16;
   endfunction

   initial begin
      int n;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_prod", 32'(prod), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("a13b11", 13, 11, 143, 1'b1);
      run_op("a15b15", 15, 15, 225, 1'b1);
      run_op("a0b9", 0, 9, 0, 1'b1);
      run_op("a9b0", 9, 0, 0, 1'b1);
      run_op("a7b6", 7, 6, 42, 1'b1);

      // Product holds its last value across idle cycles and a new accept.
      repeat (3) @(posedge clk);
      #1 check("hold_prod", 32'(prod), 32'd42);
      @(negedge clk);
      start = 1'b1; a_in = 4'd3; b_in = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_after_start", 32'(prod), 32'd42);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_prod", 32'(prod), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         check("midrst_nodone", {31'd0, done}, 32'd0);
      end
      run_op("after_rst", 12, 10, 120, 1'b1);

      // Start held high with operands changing every cycle.
      // Accepts occur at edges 0, 6 and 12, and done appears after edges 4, 10 and 16.
      for (int e = 0; e < 18; e++) begin
         @(negedge clk);
         start = 1'b1;
         a_in  = 4'(opa(e));
         b_in  = 4'(opb(e));
         @(posedge clk); #1;
         check($sformatf("hold_done_e%0d", e), {31'd0, done}, {31'd0, (e % 6) == 4});
         if ((e % 6) == 4)
            check($sformatf("hold_prod_e%0d", e), 32'(prod), 32'(opa(e - 4) * opb(e - 4)));
      end
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(posedge clk);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_op($sformatf("ex_%0dx%0d", a, b), a, b, a * b, 1'b0);

      // WIDTH=8 maximum operands.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd255; b8 = 8'd255;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'd1; b8 = 8'd2;
      n = 0;
      while (n < 30 && !done8) begin
         @(posedge clk); #1;
         n++;
      end
      check("w8_lat", 32'(n), 32'd8);
      check("w8_prod", 32'(prod8), 32'd65025);
      @(posedge clk); #1;
      check("w8_onedone", {31'd0, done8}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
